// File: rtl/tx_8b10b_stream_checker_pkg.sv
// Shared types, comma patterns and helpers for the 8b/10b TX stream checker.
package enc_chk_pkg;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } lane_state_e;

    // Leading seven bits of K28.1/K28.5/K28.7 in either disparity.
    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    function automatic logic [3:0] popcount10(input logic [9:0] w);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, w[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_8b10b_stream_checker_if.sv
// Encoder-side word bus into the checker plus its per-lane status outputs.
interface tx_8b10b_stream_checker_if #(
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 16
);
    logic                   Valid_In;
    logic [LANES*10-1:0]    TxParallel_10;
    logic [LANES-1:0]       TxDataK;
    logic                   Cnt_Clear;
    logic [LANES-1:0]       Rd_Err;
    logic [LANES-1:0]       Run_Err;
    logic [LANES-1:0]       Comma_Det;
    logic [LANES*2-1:0]     Lane_State;
    logic [LANES-1:0]       Rd_Cur;
    logic [LANES*CNT_W-1:0] Err_Cnt;

    modport master (
        output Valid_In, TxParallel_10, TxDataK, Cnt_Clear,
        input  Rd_Err, Run_Err, Comma_Det, Lane_State, Rd_Cur, Err_Cnt
    );

    modport slave (
        input  Valid_In, TxParallel_10, TxDataK, Cnt_Clear,
        output Rd_Err, Run_Err, Comma_Det, Lane_State, Rd_Cur, Err_Cnt
    );
endinterface

// File: rtl/tx_8b10b_stream_checker_lane.sv
// Single-lane checker: running disparity, cross-word run length, comma detect,
// sync FSM and saturating error counter.
module enc_chk_lane
    import enc_chk_pkg::*;
#(
    parameter int unsigned MAX_RUN    = 5,
    parameter int unsigned SYNC_WORDS = 4,
    parameter int unsigned BAD_LIMIT  = 3,
    parameter int unsigned GOOD_CLEAR = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [9:0]       word,
    input  logic             cnt_clear,
    output logic             rd_err,
    output logic             run_err,
    output logic             comma_det,
    output lane_state_e      state,
    output logic             rd_cur,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RUN_W    = $clog2(MAX_RUN + 2);
    localparam int unsigned GOOD_MAX = (SYNC_WORDS > GOOD_CLEAR) ? SYNC_WORDS : GOOD_CLEAR;
    localparam int unsigned GOOD_W   = $clog2(GOOD_MAX + 1);
    localparam int unsigned BAD_W    = $clog2(BAD_LIMIT + 1);

    logic [3:0]       ones;
    logic             rd_err_c;
    logic             rd_nxt;
    logic             run_err_c;
    logic [RUN_W-1:0] run_nxt;
    logic             last_nxt;
    logic             comma_c;
    logic             err_word;

    logic [RUN_W-1:0]  run_cnt;
    logic              last_bit;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    assign ones     = popcount10(word);
    assign comma_c  = (word[9:3] == COMMA_P) || (word[9:3] == COMMA_N);
    assign err_word = rd_err_c || run_err_c;

    // Only 4, 5 or 6 ones are legal; an illegal word still re-seeds RD from its sign.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_nxt   = rd_cur;
        rd_err_c = (ones < 4'd4) || (ones > 4'd6) ||
                   ((ones == 4'd6) && rd_cur) || ((ones == 4'd4) && !rd_cur);
        if (ones > 4'd5) begin
            rd_nxt = 1'b1;
        end else if (ones < 4'd5) begin
            rd_nxt = 1'b0;
        end
    end

    // Run scan in transmit order, seeded from the previous word's trailing run.
    always_comb begin
        run_nxt   = run_cnt;
        last_nxt  = last_bit;
        run_err_c = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if ((run_nxt != '0) && (word[i] == last_nxt)) begin
                if (run_nxt != RUN_W'(MAX_RUN + 1)) begin
                    run_nxt = run_nxt + 1'b1;
                end
            end else begin
                run_nxt = RUN_W'(1);
            end
            last_nxt = word[i];
            if (run_nxt > RUN_W'(MAX_RUN)) begin
                run_err_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err    <= 1'b0;
            run_err   <= 1'b0;
            comma_det <= 1'b0;
            state     <= LOS;
            rd_cur    <= 1'b0;
            run_cnt   <= '0;
            last_bit  <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            rd_err    <= 1'b0;
            run_err   <= 1'b0;
            comma_det <= 1'b0;
            if (valid) begin
                rd_err    <= rd_err_c;
                run_err   <= run_err_c;
                comma_det <= comma_c;
                rd_cur    <= rd_nxt;
                run_cnt   <= run_nxt;
                last_bit  <= last_nxt;
                unique case (state)
                    LOS: begin
                        if (comma_c) begin
                            state    <= ACQ;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end
                    end
                    ACQ: begin
                        if (err_word) begin
                            state <= LOS;
                        end else if (good_cnt == GOOD_W'(SYNC_WORDS - 1)) begin
                            state    <= SYNC;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (err_word) begin
                            good_cnt <= '0;
                            if (bad_cnt == BAD_W'(BAD_LIMIT - 1)) begin
                                state   <= LOS;
                                bad_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end else if (good_cnt == GOOD_W'(GOOD_CLEAR - 1)) begin
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    default: state <= LOS;
                endcase
            end
            // Clear wins over a same-cycle increment; FSM, RD and run state are unaffected.
            if (cnt_clear) begin
                err_cnt <= '0;
            end else if (valid && err_word && (state != LOS) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_8b10b_stream_checker.sv
// Multi-lane 8b/10b TX stream checker: one independent enc_chk_lane per 10-bit lane.
module tx_8b10b_stream_checker
    import enc_chk_pkg::*;
#(
    parameter int unsigned LANES      = 1,
    parameter int unsigned MAX_RUN    = 5,
    parameter int unsigned SYNC_WORDS = 4,
    parameter int unsigned BAD_LIMIT  = 3,
    parameter int unsigned GOOD_CLEAR = 8,
    parameter int unsigned CNT_W      = 16
) (
    input logic                        BitCLK_10,
    input logic                        Reset,
    tx_8b10b_stream_checker_if.slave   chk
);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_state_e lane_st;

        enc_chk_lane #(
            .MAX_RUN    (MAX_RUN),
            .SYNC_WORDS (SYNC_WORDS),
            .BAD_LIMIT  (BAD_LIMIT),
            .GOOD_CLEAR (GOOD_CLEAR),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk       (BitCLK_10),
            .rst_n     (Reset),
            .valid     (chk.Valid_In),
            .word      (chk.TxParallel_10[10*n +: 10]),
            .cnt_clear (chk.Cnt_Clear),
            .rd_err    (chk.Rd_Err[n]),
            .run_err   (chk.Run_Err[n]),
            .comma_det (chk.Comma_Det[n]),
            .state     (lane_st),
            .rd_cur    (chk.Rd_Cur[n]),
            .err_cnt   (chk.Err_Cnt[CNT_W*n +: CNT_W])
        );

        assign chk.Lane_State[2*n +: 2] = lane_st;
    end

    // The K flag is carried for downstream reporting only; comma detection ignores it.
    logic unused_k;
    assign unused_k = ^chk.TxDataK;

endmodule

// File: doc/tx_8b10b_stream_checker.md
Name: tx_8b10b_stream_checker

Overview:
- Synthesizable multi-lane monitor for the 8b/10b TX path. Sits on the encoder's 10-bit parallel output, ahead of the serializer.
- Per lane, it checks running disparity and run length. Run length is tracked across word boundaries, not only within a word.
- Detects commas, runs a per-lane sync FSM, and keeps saturating error counters that firmware or the UVM scoreboard can read.

Parameters:
- LANES, 1, number of independent 10-bit lanes.
- MAX_RUN, 5, longest legal run of identical bits.
- SYNC_WORDS, 4, consecutive clean words needed to reach SYNC.
- BAD_LIMIT, 3, error words in SYNC that force LOS.
- GOOD_CLEAR, 8, consecutive clean words in SYNC that clear the bad count.
- CNT_W, 16, error counter width.

Ports:
- BitCLK_10  in  1  word clock.
- Reset  in  1  asynchronous, active-low reset.
- Valid_In  in  1  qualifies TxParallel_10 and TxDataK this cycle.
- TxParallel_10  in  LANES*10  encoded words; lane n is [10n+9:10n]; bit 9 is transmitted first.
- TxDataK  in  LANES  control-character flag per lane (reporting only).
- Cnt_Clear  in  1  synchronous clear of all error counters.
- Rd_Err  out  LANES  one-cycle pulse: disparity violation.
- Run_Err  out  LANES  one-cycle pulse: run longer than MAX_RUN.
- Comma_Det  out  LANES  one-cycle pulse: comma found.
- Lane_State  out  LANES*2  sync state per lane (LOS=0, ACQ=1, SYNC=2).
- Rd_Cur  out  LANES  current running disparity per lane (0 = RD-, 1 = RD+).
- Err_Cnt  out  LANES*CNT_W  saturating count of error words per lane.

Behaviour:
- Reset values:
  - All pulse outputs 0; Err_Cnt 0; Lane_State LOS.
  - Rd_Cur 0 (RD-); run count 0; last bit 0.
- Latency: every output reflects the word sampled on posedge BitCLK_10 with Valid_In=1, registered, one cycle later.
- Valid_In=0: no lane state, RD, run tracking or counters change, and pulses are 0.
- Word disparity d = ones - zeros.
  - |d| not in {0, 2}: Rd_Err.
  - d = +2 while RD+, or d = -2 while RD-: Rd_Err.
  - On d = +2, RD becomes +; on d = -2, RD becomes -; otherwise RD is unchanged.
  - On an illegal d, RD is still set from sign(d) so the checker re-seeds instead of cascading errors.
- Run length:
  - Seed from the previous word's last bit (bit 0) and its run count; scan bits 9 down to 0.
  - Run_Err if any run exceeds MAX_RUN.
  - Carried count saturates at MAX_RUN+1.
  - After reset the carried run is 0, so the first word is checked in isolation.
- Comma: TxParallel_10[9:3] equals 0011111 or 1100000 sets Comma_Det. This is independent of TxDataK.
- Error word: Rd_Err or Run_Err is set for that word.
- Sync FSM, per lane, updated on valid words only:
  - LOS: errors are not counted and RD re-seeds freely. A comma moves the lane to ACQ and clears the good count.
  - ACQ: an error word returns the lane to LOS. SYNC_WORDS consecutive clean words move it to SYNC.
  - SYNC:
    - An error word increments the bad count and clears the good count.
    - GOOD_CLEAR consecutive clean words clear the bad count.
    - When the bad count reaches BAD_LIMIT, go to LOS.
- Err_Cnt:
  - Increments on error words in ACQ or SYNC, and saturates at all-ones.
  - Cnt_Clear has priority over a same-cycle increment and leaves the FSM, RD and run state untouched.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous); there is no partial state.
- Lanes are fully independent; an error on one lane never affects another.

Decomposition:
- Package enc_chk_pkg:
  - lane_state_e enum (LOS, ACQ, SYNC).
  - Comma constants COMMA_P=7'b0011111 and COMMA_N=7'b1100000.
  - Function popcount10.
- One sub-module, enc_chk_lane: a single-lane checker holding RD, run, FSM and counter state. The top level generates LANES instances and slices the buses.

Test Plan:
- Disparity alternation: after reset, LANES=1, Valid_In=1, send 0011111010 (K28.5 RD-) then 1100000101 (K28.5 RD+). Required: Comma_Det pulses both cycles; Rd_Cur goes 1 then 0; no Rd_Err; Lane_State goes to ACQ.
- Repeated polarity: send 0011111010 twice. Required: Rd_Err=1 on the second word only; Rd_Cur stays 1.
- Run across boundary: send 0000011111 then 1010101010. Required: Run_Err on the second word (run of 6 ones); no Rd_Err.
- Sync acquisition and loss: comma plus 4 clean words gives SYNC; 3 error words in SYNC return LOS.
  - Check Err_Cnt counts the 3 SYNC error words.
  - Check errors while in LOS are not counted.
- Saturation and clear: with CNT_W=2, 5 error words in ACQ/SYNC give Err_Cnt=3. Assert Cnt_Clear together with an error word: Err_Cnt=0.
- Multi-lane and reset: LANES=4 with an error on lane 2 only; only Rd_Err[2] pulses. Drop Reset mid-word: all outputs return to reset values immediately.
